// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control unit.
// A Moore FSM steps one instruction through FETCH .. writeback using a shared
// memory and a single ALU, and an ALU decoder turns the FSM's ALUOp request
// into the ALUControl code. The only combinational inputs to the outputs are
// MemReady (fetch enables) and Zero (branch taken), both used in one state each.
//
// Memory handshake: the controller holds a request (AdrSrc, MemWrite and all
// selects) stable in FETCH, MEMREAD or MEMWRITE and waits there; the access
// completes in the cycle MemReady = 1, and only that cycle may commit
// IRWrite/PCWrite or leave the state.
//
// state_dbg presents the FSM state encoding for observation:
//   0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE,
//   6 EXECUTER, 7 EXECUTEI, 8 ALUWB, 9 BRANCH, 10 JAL, 11 ILLEGAL.
//
// ALUCTRL_W must be at least 3; bits above [2:0] are always driven 0.

module mc_controller #(
  parameter int ALUCTRL_W   = 3,
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 RegWrite,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Illegal,
  output logic [3:0]           state_dbg
);

  // Opcodes the controller recognises.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALUOp: what the FSM asks of the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl3;
  logic       branch_ok;
  logic       branch_taken;

  assign state_dbg = state;

  // beq is always supported; bne only when SUPPORT_BNE is set.
  assign branch_ok = (funct3 == 3'b000) ||
                     ((funct3 == 3'b001) && SUPPORT_BNE);

  // funct3[0] distinguishes bne (taken on !Zero) from beq (taken on Zero).
  assign branch_taken = funct3[0] ? ~Zero : Zero;

  // State register: reset aborts any instruction and returns to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next-state logic: memory states wait on MemReady, DECODE dispatches on op.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (MemReady) next_state = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECUTER;
          OP_ITYPE:          next_state = S_EXECUTEI;
          OP_BRANCH:         next_state = branch_ok ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            next_state = S_JAL;
          default:           next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        // op[5] separates stores (1) from loads (0).
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        if (MemReady) next_state = S_MEMWB;
      end
      S_MEMWRITE: begin
        if (MemReady) next_state = S_FETCH;
      end
      S_MEMWB:    next_state = S_FETCH;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JAL:      next_state = S_FETCH;
      S_ILLEGAL:  next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  // Output logic: per-state enables and selects; anything unlisted stays 0.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    Illegal   = 1'b0;
    alu_op    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        // PC + 4 goes straight from the ALU result into the PC.
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        // Precompute the branch/jump target OldPC + imm.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_ADD;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_ADD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWRITE: begin
        // Held for the whole stall until memory accepts the write.
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        // ALUOut still holds the target computed in DECODE.
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        PCWrite = branch_taken;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_ILLEGAL: begin
        Illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ALU decoder: map ALUOp and the funct fields to a 3-bit ALU operation.
  always_comb begin
    alu_ctrl3 = 3'b000;
    case (alu_op)
      ALUOP_ADD: alu_ctrl3 = 3'b000;
      ALUOP_SUB: alu_ctrl3 = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5] = 1) can encode sub; addi ignores funct7b5.
          3'b000:  alu_ctrl3 = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl3 = 3'b101;
          3'b100:  alu_ctrl3 = 3'b100;
          3'b110:  alu_ctrl3 = 3'b011;
          3'b111:  alu_ctrl3 = 3'b010;
          default: alu_ctrl3 = 3'b000;
        endcase
      end
      default: alu_ctrl3 = 3'b000;
    endcase
  end

  // Widen to ALUCTRL_W with the upper bits tied low.
  always_comb begin
    ALUControl      = '0;
    ALUControl[2:0] = alu_ctrl3;
  end

  // Immediate format from the opcode alone, valid in every state.
  always_comb begin
    case (op)
      OP_ITYPE, OP_LOAD: ImmSrc = 2'b00;
      OP_STORE:          ImmSrc = 2'b01;
      OP_BRANCH:         ImmSrc = 2'b10;
      OP_JAL:            ImmSrc = 2'b11;
      default:           ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller.
// Two instances share all inputs: u0 (ALUCTRL_W = 5, bne supported) and
// u1 (ALUCTRL_W = 3, bne illegal). Both take the same number of cycles for
// every instruction, so they stay in lockstep and are checked every cycle.
// Expected output vectors are pushed when a cycle's stimulus is driven and
// popped at the following falling edge, when the outputs are compared.

module tb_mc_controller;

  localparam int VW = 21;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  logic       pcw0, adr0, mw0, irw0, rw0, ill0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [4:0] alu0;
  logic [3:0] st0;
  logic       pcw1, adr1, mw1, irw1, rw1, ill1;
  logic [1:0] rs1, sa1, sb1, imm1;
  logic [2:0] alu1;
  logic [3:0] st1;

  mc_controller #(.ALUCTRL_W(5), .SUPPORT_BNE(1'b1)) u0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .MemReady(mem_ready),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0),
    .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .RegWrite(rw0),
    .ImmSrc(imm0), .ALUControl(alu0), .Illegal(ill0), .state_dbg(st0)
  );

  mc_controller #(.ALUCTRL_W(3), .SUPPORT_BNE(1'b0)) u1 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .MemReady(mem_ready),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1),
    .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .RegWrite(rw1),
    .ImmSrc(imm1), .ALUControl(alu1), .Illegal(ill1), .state_dbg(st1)
  );

  logic [VW-1:0] obs0, obs1;
  assign obs0 = {st0, pcw0, adr0, mw0, irw0, rs0, sa0, sb0, rw0, imm0, alu0[2:0], ill0};
  assign obs1 = {st1, pcw1, adr1, mw1, irw1, rs1, sa1, sb1, rw1, imm1, alu1, ill1};

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp0_q[$];
  logic [VW-1:0] exp1_q[$];
  int tests_run = 0;
  int failures  = 0;

  function automatic logic [VW-1:0] mk(
    input logic [3:0] st, input logic pcw, input logic adr, input logic mw,
    input logic irw, input logic [1:0] rs, input logic [1:0] sa,
    input logic [1:0] sb, input logic rw, input logic [1:0] imm,
    input logic [2:0] alu, input logic ill);
    return {st, pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu, ill};
  endfunction

  task automatic compare(input string tag);
    logic [VW-1:0] e0, e1;
    e0 = exp0_q.pop_front();
    e1 = exp1_q.pop_front();
    tests_run++;
    assert (obs0 === e0) else begin
      failures++;
      $error("FAIL %s u0: observed %h expected %h", tag, obs0, e0);
    end
    tests_run++;
    assert (obs1 === e1) else begin
      failures++;
      $error("FAIL %s u1: observed %h expected %h", tag, obs1, e1);
    end
    tests_run++;
    assert (alu0[4:3] === 2'b00) else begin
      failures++;
      $error("FAIL %s alu_upper: observed %b expected 00", tag, alu0[4:3]);
    end
  endtask

  // One clock cycle: inputs are already driven; check at the falling edge.
  task automatic step(input logic [VW-1:0] e0, input logic [VW-1:0] e1,
                      input string tag);
    exp0_q.push_back(e0);
    exp1_q.push_back(e1);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_fetch(input logic [1:0] imm, input int stall);
    logic [VW-1:0] e;
    for (int i = 0; i < stall; i++) begin
      mem_ready = 1'b0;
      e = mk(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, imm, 3'b000, 0);
      step(e, e, "fetch_stall");
    end
    mem_ready = 1'b1;
    e = mk(S_FETCH, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, imm, 3'b000, 0);
    step(e, e, "fetch");
    e = mk(S_DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, imm, 3'b000, 0);
    step(e, e, "decode");
  endtask

  task automatic run_lw(input int rd_stall);
    logic [VW-1:0] e;
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    do_fetch(2'b00, 0);
    e = mk(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 3'b000, 0);
    step(e, e, "lw_memadr");
    e = mk(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0);
    for (int i = 0; i < rd_stall; i++) begin
      mem_ready = 1'b0;
      step(e, e, "lw_memread_stall");
    end
    mem_ready = 1'b1;
    step(e, e, "lw_memread");
    e = mk(S_MEMWB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 3'b000, 0);
    step(e, e, "lw_memwb");
  endtask

  task automatic run_sw(input int if_stall, input int wr_stall);
    logic [VW-1:0] e;
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    do_fetch(2'b01, if_stall);
    e = mk(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b01, 3'b000, 0);
    step(e, e, "sw_memadr");
    e = mk(S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 3'b000, 0);
    for (int i = 0; i < wr_stall; i++) begin
      mem_ready = 1'b0;
      step(e, e, "sw_memwrite_stall");
    end
    mem_ready = 1'b1;
    step(e, e, "sw_memwrite");
  endtask

  task automatic run_alu(input logic [6:0] opc, input logic [2:0] f3,
                         input logic f7, input logic [2:0] exp_alu);
    logic [VW-1:0] e;
    op = opc; funct3 = f3; funct7b5 = f7;
    do_fetch(2'b00, 0);
    if (opc[5])
      e = mk(S_EXECUTER, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b00, exp_alu, 0);
    else
      e = mk(S_EXECUTEI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, exp_alu, 0);
    step(e, e, "alu_execute");
    e = mk(S_ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 3'b000, 0);
    step(e, e, "alu_wb");
  endtask

  // legal0/legal1: whether u0/u1 accept this branch; taken is the PC decision.
  task automatic run_branch(input logic [2:0] f3, input logic z,
                            input logic taken, input logic legal0,
                            input logic legal1);
    logic [VW-1:0] e0, e1, eb, ei;
    op = 7'b1100011; funct3 = f3; funct7b5 = 1'b0;
    zero = ~z;
    do_fetch(2'b10, 0);
    zero = z;
    eb = mk(S_BRANCH, taken, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 3'b001, 0);
    ei = mk(S_ILLEGAL, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 3'b000, 1);
    e0 = legal0 ? eb : ei;
    e1 = legal1 ? eb : ei;
    step(e0, e1, "branch");
    zero = 1'b0;
  endtask

  task automatic run_jal();
    logic [VW-1:0] e;
    op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
    do_fetch(2'b11, 0);
    e = mk(S_JAL, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b11, 3'b000, 0);
    step(e, e, "jal");
  endtask

  task automatic run_illegal(input logic [6:0] opc);
    logic [VW-1:0] e;
    op = opc; funct3 = 3'b000; funct7b5 = 1'b0;
    do_fetch(2'b00, 0);
    e = mk(S_ILLEGAL, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 3'b000, 1);
    step(e, e, "illegal");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [VW-1:0] e;
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0;

    // Reset values with MemReady low.
    e = mk(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 2'b00, 3'b000, 0);
    step(e, e, "reset");
    reset = 1'b0;

    run_lw(0);
    run_lw(2);
    run_sw(1, 3);
    run_sw(0, 0);

    // ALU decode across opcodes and funct fields.
    run_alu(7'b0110011, 3'b000, 1'b1, 3'b001);  // sub
    run_alu(7'b0010011, 3'b000, 1'b1, 3'b000);  // addi ignores funct7b5
    run_alu(7'b0110011, 3'b000, 1'b0, 3'b000);  // add
    run_alu(7'b0110011, 3'b010, 1'b0, 3'b101);  // slt
    run_alu(7'b0010011, 3'b100, 1'b0, 3'b100);  // xori
    run_alu(7'b0110011, 3'b110, 1'b0, 3'b011);  // or
    run_alu(7'b0010011, 3'b111, 1'b0, 3'b010);  // andi
    run_alu(7'b0110011, 3'b001, 1'b0, 3'b000);  // unlisted funct3
    run_alu(7'b0010011, 3'b010, 1'b0, 3'b101);  // slti

    // Branches: beq/bne taken and not taken, unsupported funct3.
    run_branch(3'b000, 1'b1, 1'b1, 1'b1, 1'b1);
    run_branch(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    run_branch(3'b001, 1'b1, 1'b0, 1'b1, 1'b0);
    run_branch(3'b001, 1'b0, 1'b1, 1'b1, 1'b0);
    run_branch(3'b100, 1'b1, 1'b0, 1'b0, 1'b0);

    run_jal();
    run_illegal(7'b1110011);
    run_illegal(7'b0000000);
    run_alu(7'b0110011, 3'b000, 1'b1, 3'b001);

    // Reset in MEMWRITE with MemWrite high: aborts before the next edge.
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    do_fetch(2'b01, 0);
    e = mk(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b01, 3'b000, 0);
    step(e, e, "rst_memadr");
    mem_ready = 1'b0;
    e = mk(S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 3'b000, 0);
    step(e, e, "rst_memwrite");
    reset = 1'b1;
    #1;
    e = mk(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 2'b01, 3'b000, 0);
    exp0_q.push_back(e);
    exp1_q.push_back(e);
    compare("async_reset");
    @(posedge clk);
    #1;
    step(e, e, "reset_held");
    reset = 1'b0;
    run_lw(1);
    run_jal();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
